block_sort_buffer: RTL and testbench
====================================

# block_sort_buffer

Parametrised per-row block-metadata sorter. It accepts a row's (column, index) pairs over a valid/ready stream, keeps them sorted by column index as they arrive (insertion sort), and replays them in ascending column order with backpressure. It sits between the sparse block scheduler and the block fetch/dispatch stage, and it supersedes the fixed-width, single-pass bubble reorder stage. Ordering is fully sorted and stable, with explicit row framing and overflow reporting.

## Interface
- MAX_BLOCKS, 128: entries per row; must be ≥ 2.
- COL_W, 16: width of the block column index.
- IDX_W, 32: width of the block storage index.
- CNT_W, $clog2(MAX_BLOCKS+1): occupancy width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat carries a block.
- in_row_done  in  1  row terminator; may coincide with in_valid (that beat belongs to the row).
- in_ready  out  1  beat/terminator accepted when (in_valid|in_row_done)&in_ready.
- in_col  in  COL_W  block column.
- in_idx  in  IDX_W  block index.
- out_valid  out  1  sorted entry available.
- out_ready  in  1  consumer accepts entry.
- out_col  out  COL_W  sorted column.
- out_idx  out  IDX_W  matching index.
- out_last  out  1  qualifies the final entry of the row.
- out_row_done  out  1  one-cycle pulse closing the row (also for empty rows).
- out_overflow  out  1  valid with out_row_done; row dropped ≥1 block.
- occupancy  out  CNT_W  entries currently stored.

## Operation
- States: COLLECT, EMIT, DONE. Reset → COLLECT.
- Reset values: in_ready=0 during reset, then 1. out_valid, out_last, out_row_done, out_overflow = 0. occupancy=0. out_col and out_idx = 0.
- COLLECT: in_ready=1.
  - Accepted in_valid beat is inserted at position p = number of stored entries with col ≤ in_col.
  - Entries at p..count-1 shift up one slot; count increments.
  - Equal columns keep arrival order (stable sort).
- Overflow: a beat arriving when count==MAX_BLOCKS is accepted and discarded, and the sticky overflow flag is set. Stored contents are unchanged.
- Accepted in_row_done:
  - If the resulting count > 0, go to EMIT with rd_ptr=0.
  - If the count is 0, go straight to DONE.
- EMIT:
  - in_ready=0, out_valid=1.
  - out_col/out_idx = mem[rd_ptr]; out_last = (rd_ptr==count-1).
  - On each handshake rd_ptr increments. The handshake on out_last goes to DONE.
  - With out_ready=0, the outputs hold stable.
- DONE (one cycle):
  - out_row_done=1; out_overflow=flag.
  - Clears count, rd_ptr and the flag, then returns to COLLECT.
- occupancy reflects count; it does not decrement during EMIT and is cleared in DONE.
- rst_n assertion in any state aborts the row. Every output returns to its reset value asynchronously, and stored contents are invalidated.

## Timing
- Insertion: one beat per cycle at full throughput. occupancy updates the cycle after acceptance.
- Row terminator accepted at cycle T → out_valid=1 at T+1 with the smallest column. For an empty row, out_row_done=1 at T+1.
- Emit: one entry per cycle while out_ready=1. An N-entry row needs N cycles after T.
- Last handshake at cycle E → out_row_done pulse at E+1 → in_ready=1 at E+2.
- The block is non-pipelined across rows: the next row waits for DONE.
- Insertion compare is a parallel MAX_BLOCKS-wide ≤ compare plus a priority shift.
- out_col and out_idx are muxed from registered storage with no combinational path from the inputs.

## Test plan
- Insert cols 7,3,9,1 (idx 0..3), then row_done → outputs (1,3),(3,1),(7,0),(9,2). out_last on (9,2). out_row_done one cycle after, out_overflow=0.
- Duplicates: cols 5,2,5,2 idx 10,11,12,13 → (2,11),(2,13),(5,10),(5,12), confirming stable order.
- Empty row: in_row_done alone at T → out_row_done at T+1 with out_valid never high. in_ready returns to 1 at T+2.
- Overflow with MAX_BLOCKS=4: six beats cols 6,5,4,3,2,1 → emits 3,4,5,6 and out_overflow=1 with out_row_done. The next row reports out_overflow=0.
- Backpressure: toggle out_ready randomly during a 16-entry row → outputs stable while stalled. All 16 entries are delivered sorted, with in_ready=0 throughout.
- Reset mid-EMIT: assert rst_n low after 2 of 4 entries → out_valid=0 and occupancy=0 immediately. A new row after reset sorts correctly with no stale entries.

Source files
------------

// File: rtl/block_sort_buffer.sv
// Per-row block metadata sorter: insertion-sorts (col, idx) pairs as they
// arrive, then replays them in ascending, stable column order.
module block_sort_buffer #(
   parameter int MAX_BLOCKS = 128,
   parameter int COL_W      = 16,
   parameter int IDX_W      = 32,
   localparam int CNT_W     = $clog2(MAX_BLOCKS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_row_done,
   output logic             in_ready,
   input  logic [COL_W-1:0] in_col,
   input  logic [IDX_W-1:0] in_idx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [COL_W-1:0] out_col,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_row_done,
   output logic             out_overflow,
   output logic [CNT_W-1:0] occupancy
);

   localparam int ADDR_W = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;

   // Handshake: an input beat/terminator transfers when (in_valid|in_row_done)
   // && in_ready on a rising clk; an output entry transfers when
   // out_valid && out_ready. Neither ready depends combinationally on its valid.

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      EMIT    = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic                 alive_q;
   logic [CNT_W-1:0]     count;
   logic [CNT_W-1:0]     rd_ptr;
   logic                 ovf_flag;
   logic [COL_W-1:0]     mem_col [MAX_BLOCKS];
   logic [IDX_W-1:0]     mem_idx [MAX_BLOCKS];
   logic [MAX_BLOCKS-1:0] shift;
   logic [MAX_BLOCKS-1:0] shift_up;
   logic                 full;
   logic                 do_insert;
   logic                 do_drop;
   logic [ADDR_W-1:0]    rd_addr;

   assign full      = (count == CNT_W'(MAX_BLOCKS));
   assign do_insert = in_ready && in_valid && !full;
   assign do_drop   = in_ready && in_valid && full;
   assign rd_addr   = rd_ptr[ADDR_W-1:0];
   assign occupancy = count;

   // Stored entries strictly greater than the new column move up one slot;
   // equal columns stay below the newcomer, which keeps the sort stable.
   always_comb begin
      shift = '0;
      for (int i = 0; i < MAX_BLOCKS; i++) begin
         shift[i] = (CNT_W'(i) < count) && (mem_col[i] > in_col);
      end
   end

   assign shift_up = {shift[MAX_BLOCKS-2:0], 1'b0};

   always_ff @(posedge clk) begin
      if (do_insert) begin
         for (int i = 0; i < MAX_BLOCKS; i++) begin
            if (shift_up[i]) begin
               mem_col[i] <= mem_col[(i == 0) ? 0 : i - 1];
               mem_idx[i] <= mem_idx[(i == 0) ? 0 : i - 1];
            end else if (shift[i] || (CNT_W'(i) == count)) begin
               mem_col[i] <= in_col;
               mem_idx[i] <= in_idx;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= COLLECT;
         alive_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         alive_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         rd_ptr   <= '0;
         ovf_flag <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (do_insert) count <= count + CNT_W'(1);
               if (do_drop) ovf_flag <= 1'b1;
            end
            EMIT: begin
               if (out_ready) rd_ptr <= rd_ptr + CNT_W'(1);
            end
            DONE: begin
               count    <= '0;
               rd_ptr   <= '0;
               ovf_flag <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt    = state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_col      = '0;
      out_idx      = '0;
      out_last     = 1'b0;
      out_row_done = 1'b0;
      out_overflow = 1'b0;
      case (state)
         COLLECT: begin
            in_ready = alive_q;
            if (alive_q && in_row_done) begin
               // A beat on the terminator cycle counts toward the row.
               if ((count != '0) || in_valid) state_nxt = EMIT;
               else                           state_nxt = DONE;
            end
         end
         EMIT: begin
            out_valid = 1'b1;
            out_col   = mem_col[rd_addr];
            out_idx   = mem_idx[rd_addr];
            out_last  = (rd_ptr == count - CNT_W'(1));
            if (out_ready && out_last) state_nxt = DONE;
         end
         DONE: begin
            out_row_done = 1'b1;
            out_overflow = ovf_flag;
            state_nxt    = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

endmodule

// File: tb/tb_block_sort_buffer.sv
// Scoreboarded random/directed bench for block_sort_buffer with a rank-based
// stable-sort reference model.
module tb_block_sort_buffer;

   localparam int MAXB  = 16;
   localparam int COL_W = 16;
   localparam int IDX_W = 32;
   localparam int CNT_W = $clog2(MAXB + 1);
   localparam int WW    = 1 + COL_W + IDX_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_row_done = 1'b0;
   logic             in_ready;
   logic [COL_W-1:0] in_col = '0;
   logic [IDX_W-1:0] in_idx = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [COL_W-1:0] out_col;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;
   logic             out_row_done;
   logic             out_overflow;
   logic [CNT_W-1:0] occupancy;

   block_sort_buffer #(.MAX_BLOCKS(MAXB), .COL_W(COL_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_row_done(in_row_done), .in_ready(in_ready),
      .in_col(in_col), .in_idx(in_idx),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_col(out_col), .out_idx(out_idx), .out_last(out_last),
      .out_row_done(out_row_done), .out_overflow(out_overflow),
      .occupancy(occupancy)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WW-1:0] exp_q[$];
   logic          ovf_q[$];

   int            row_n;
   logic [COL_W-1:0] row_col[64];
   logic [IDX_W-1:0] row_idx[64];
   bit            bp_rand = 1'b0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Output position of an entry = entries with a smaller column plus
   // earlier-arriving entries with the same column; beats past capacity vanish.
   task automatic push_expected();
      int kept;
      int order[64];
      kept = (row_n > MAXB) ? MAXB : row_n;
      for (int i = 0; i < kept; i++) begin
         int rank = 0;
         for (int j = 0; j < kept; j++) begin
            if (row_col[j] < row_col[i] || (row_col[j] == row_col[i] && j < i)) rank++;
         end
         order[rank] = i;
      end
      for (int r = 0; r < kept; r++) begin
         exp_q.push_back({(r == kept - 1), row_col[order[r]], row_idx[order[r]]});
      end
      ovf_q.push_back(row_n > MAXB);
   endtask

   // ---------------- drivers ----------------
   task automatic send(input logic v, input logic rd, input logic [COL_W-1:0] c,
                       input logic [IDX_W-1:0] x);
      int t = 0;
      in_valid = v; in_row_done = rd; in_col = c; in_idx = x;
      @(negedge clk);
      while (!in_ready && t < 2000) begin
         t++;
         @(negedge clk);
      end
      if (!in_ready) chk(1'b0, "in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_row_done = 1'b0;
   endtask

   task automatic drive_row(input bit split_term);
      for (int i = 0; i < row_n; i++) begin
         send(1'b1, (i == row_n - 1) && !split_term, row_col[i], row_idx[i]);
      end
      if (row_n == 0 || split_term) send(1'b0, 1'b1, '0, '0);
   endtask

   task automatic rand_row(input int n, input int col_hi);
      row_n = n;
      for (int i = 0; i < n; i++) begin
         row_col[i] = COL_W'($urandom_range(0, col_hi));
         row_idx[i] = $urandom;
      end
      push_expected();
      drive_row($urandom_range(0, 1) == 1);
   endtask

   always begin
      @(posedge clk);
      #1;
      if (bp_rand) out_ready = ($urandom_range(0, 2) != 0);
   end

   // ---------------- monitor / scoreboard ----------------
   logic          prev_stall, prev_last, prev2_last;
   logic [WW-1:0] prev_word;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall <= 1'b0; prev_last <= 1'b0; prev2_last <= 1'b0;
      end else begin
         logic [WW-1:0] got;
         got = {out_last, out_col, out_idx};
         if (prev_stall) chk(out_valid && got == prev_word, "stall_stable", got, prev_word);
         if (prev_last) chk(out_row_done == 1'b1, "row_done_after_last", out_row_done, 1);
         if (prev2_last) begin
            chk(in_ready == 1'b1, "in_ready_after_done", in_ready, 1);
            chk(occupancy == '0, "occupancy_cleared", occupancy, 0);
         end
         if (out_valid) chk(in_ready == 1'b0, "in_ready_low_in_emit", in_ready, 0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk(1'b0, "unexpected_entry", got, 0);
            else begin
               logic [WW-1:0] e;
               e = exp_q.pop_front();
               chk(got == e, "entry", got, e);
            end
         end
         if (out_row_done) begin
            chk(out_valid == 1'b0, "valid_low_at_row_done", out_valid, 0);
            if (ovf_q.size() == 0) chk(1'b0, "unexpected_row_done", 1, 0);
            else begin
               logic e_ovf;
               e_ovf = ovf_q.pop_front();
               chk(out_overflow == e_ovf, "overflow", out_overflow, e_ovf);
            end
         end
         prev2_last <= prev_last;
         prev_last  <= out_valid && out_ready && out_last;
         prev_stall <= out_valid && !out_ready;
         prev_word  <= got;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      #13;
      chk(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
      chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
      chk(out_last == 1'b0, "rst_out_last", out_last, 0);
      chk(out_row_done == 1'b0, "rst_out_row_done", out_row_done, 0);
      chk(out_overflow == 1'b0, "rst_out_overflow", out_overflow, 0);
      chk(occupancy == '0, "rst_occupancy", occupancy, 0);
      chk(out_col == '0, "rst_out_col", out_col, 0);
      chk(out_idx == '0, "rst_out_idx", out_idx, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Basic sort, terminator on its own beat
      row_n = 4;
      row_col[0] = 7; row_col[1] = 3; row_col[2] = 9; row_col[3] = 1;
      for (int i = 0; i < 4; i++) row_idx[i] = i;
      push_expected();
      for (int i = 0; i < 4; i++) send(1'b1, 1'b0, row_col[i], row_idx[i]);
      chk(occupancy == CNT_W'(4), "occupancy_after_4", occupancy, 4);
      send(1'b0, 1'b1, '0, '0);

      // Duplicates, terminator on the final beat
      row_n = 4;
      row_col[0] = 5; row_col[1] = 2; row_col[2] = 5; row_col[3] = 2;
      for (int i = 0; i < 4; i++) row_idx[i] = 10 + i;
      push_expected();
      drive_row(1'b0);

      // Empty row timing
      row_n = 0;
      push_expected();
      send(1'b0, 1'b1, '0, '0);
      @(negedge clk);
      chk(out_row_done == 1'b1, "empty_row_done", out_row_done, 1);
      chk(out_valid == 1'b0, "empty_no_valid", out_valid, 0);
      @(negedge clk);
      chk(in_ready == 1'b1, "empty_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Full row under random backpressure
      bp_rand = 1'b1;
      rand_row(MAXB, 7);

      // Overflow row, then a clean row
      rand_row(MAXB + 4, 40);
      rand_row(5, 40);

      for (int r = 0; r < 20; r++) rand_row($urandom_range(0, MAXB + 2), $urandom_range(0, 20));

      // Reset mid-EMIT after two of four entries
      bp_rand = 1'b0;
      begin
         int t = 0;
         while ((exp_q.size() != 0 || ovf_q.size() != 0) && t < 5000) begin
            t++;
            @(posedge clk);
         end
      end
      #1;
      out_ready = 1'b1;
      row_n = 4;
      for (int i = 0; i < 4; i++) begin
         row_col[i] = COL_W'(20 - 3 * i);
         row_idx[i] = 100 + i;
      end
      push_expected();
      drive_row(1'b1);
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk(out_valid == 1'b0, "midrst_out_valid", out_valid, 0);
      chk(occupancy == '0, "midrst_occupancy", occupancy, 0);
      chk(in_ready == 1'b0, "midrst_in_ready", in_ready, 0);
      exp_q.delete();
      ovf_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bp_rand = 1'b1;
      rand_row(6, 50);

      begin
         int t = 0;
         while ((exp_q.size() != 0 || ovf_q.size() != 0) && t < 5000) begin
            t++;
            @(posedge clk);
         end
         if (exp_q.size() != 0 || ovf_q.size() != 0)
            chk(1'b0, "drain_timeout", exp_q.size(), 0);
      end
      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
